if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Two-entry elastic pipeline buffer between the fetch stage and the decode stage of the 16-bit RISC pipeline. Accepts one fetch packet (instruction, immediate, PC, next PC, bubble flag) per cycle, drops bubble packets, and presents packets in order to decode under a valid/ready handshake. Absorbs one cycle of decode back-pressure without stalling fetch. Discards all held packets on a control-flow flush (taken jump or interrupt).

## Interface
- INSTR_W, 16, instruction and immediate width
- PC_W, 32, program-counter width
- NOP_INSTR, 16'h0000, instruction word presented when the buffer is empty
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents a packet this cycle
- in_ready  out  1  buffer can accept; fetch drives its stall from !in_ready
- in_instr  in  INSTR_W  fetched instruction word
- in_imm  in  INSTR_W  immediate word attached to the instruction
- in_pc  in  PC_W  PC of the instruction
- in_next_pc  in  PC_W  PC of the following instruction
- in_bubble  in  1  packet is a bubble; never stored
- flush  in  1  discard all held packets and the incoming packet
- out_valid  out  1  head packet is valid
- out_ready  in  1  decode consumes the head packet this cycle
- out_instr  out  INSTR_W  head instruction; NOP_INSTR when empty
- out_imm, out_pc, out_next_pc  out  INSTR_W/PC_W/PC_W  head fields; zero when empty
- occupancy  out  2  number of stored packets, 0..2
- bubble_count  out  16  dropped-bubble count (only with IF_ID_BUBBLE_CNT_EN)

## Operation
- Storage: two entries, 1-bit write pointer, 1-bit read pointer, 2-bit count; pointers wrap 1→0.
- Count state machine: EMPTY (0), ONE (1), FULL (2).
- push = in_valid & in_ready & !in_bubble & !flush; pop = out_valid & out_ready & !flush.
- in_ready = (count != 2); decoded from registered state only; no combinational path from out_ready or in_valid.
- out_valid = (count != 0); head fields driven from the entry at the read pointer.
- Transitions: EMPTY→ONE on push; ONE→FULL on push without pop; ONE→EMPTY on pop without push; ONE stays ONE on push+pop; FULL→ONE on pop; FULL cannot push.
- No bypass: a packet pushed in cycle N never appears on the outputs in cycle N.
- Bubble: in_valid & in_bubble accepted (in_ready=1) is consumed and dropped; state unchanged.
- Flush: count, read and write pointers go to 0 at the next edge; simultaneous push and pop are both cancelled; flush dominates all other events.
- Entry contents are not cleared on pop or flush; only outputs are forced via out_valid.

## Timing
- Reset (rst low, asynchronous): count=0, pointers=0, out_valid=0, out_instr=NOP_INSTR, out_imm/out_pc/out_next_pc=0, occupancy=0, in_ready=1, bubble_count=0. Storage flops also cleared.
- Latency: push at edge N → out_valid=1 with that packet from cycle N+1.
- Throughput: one packet per cycle when out_ready held high.
- Back-pressure: out_ready low for one cycle with continuous input fills to FULL; in_ready falls the cycle after FULL is reached, never earlier.
- Reset mid-operation: all held packets lost; first push after rst rises behaves as from EMPTY.

## Configuration
- IF_ID_BUBBLE_CNT_EN defined: bubble_count port present; increments by 1 on each dropped bubble (in_valid & in_bubble & in_ready), including during flush; saturates at 16'hFFFF; cleared only by reset.
- Not defined: port and counter absent; all other behaviour identical.

## Structure
- Shared pipeline package: INSTR_W, PC_W, NOP_INSTR constants and the fetch-packet struct (instr, imm, pc, next_pc) reused by fetch and decode.
- One sub-module: if_id_slot, a single packet register with write enable and asynchronous active-low clear, instantiated twice.

## Test plan
- Reset then single push instr 16'h1234, pc 32'h20, out_ready=1 → out_valid=1 next cycle with out_instr 16'h1234, out_pc 32'h20; EMPTY again after pop; out_instr returns to 16'h0000.
- Three back-to-back pushes with out_ready=0 → occupancy 1 then 2, in_ready=0 from third cycle, third packet not stored; releasing out_ready drains first two in order.
- Push with in_bubble=1 at pc 32'h22 → not stored, occupancy unchanged, bubble_count increments to 1 (macro on).
- FULL buffer plus flush with simultaneous in_valid and out_ready → occupancy 0, out_valid 0 next cycle, incoming packet absent.
- ONE state with simultaneous push and pop → occupancy stays 1, head is new packet, order preserved across pointer wrap.
- Assert rst low while FULL → outputs at reset values immediately, before next clock edge.

Source files
------------

// File: rtl/if_id_buffer_pkg.sv
// Shared fetch/decode pipeline definitions: widths, NOP word, fetch-packet
// struct and the buffer count states.
package if_id_buffer_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR      = 16'h0000;
    localparam logic [15:0]        BUBBLE_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] imm;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    next_pc;
    } fetch_pkt_t;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == BUBBLE_CNT_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/if_id_slot.sv
// Single fetch-packet register with write enable and asynchronous
// active-low clear.
module if_id_slot
    import if_id_buffer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_we,
    input  fetch_pkt_t i_d,
    output fetch_pkt_t o_q
);

    fetch_pkt_t r_q;

    // Packet storage, loaded only when this slot is the write target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry elastic fetch->decode buffer; drops bubbles, flushes on control
// flow. Define IF_ID_BUBBLE_CNT_EN to add the saturating bubble_count port.
module if_id_buffer
    import if_id_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [INSTR_W-1:0] in_imm,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [PC_W-1:0]    in_next_pc,
    input  logic               in_bubble,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [INSTR_W-1:0] out_imm,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_next_pc,
    output logic [1:0]         occupancy
`ifdef IF_ID_BUBBLE_CNT_EN
    ,
    output logic [15:0]        bubble_count
`endif
);

    cnt_state_e r_state;
    cnt_state_e w_state_next;
    logic       r_wptr;
    logic       r_rptr;
    logic       w_push;
    logic       w_pop;
    fetch_pkt_t w_in_pkt;
    fetch_pkt_t w_slot0;
    fetch_pkt_t w_slot1;
    fetch_pkt_t w_head;

    // Handshake terms come only from registered state, never from out_ready.
    assign in_ready  = (r_state != CNT_FULL);
    assign out_valid = (r_state != CNT_EMPTY);
    assign w_push    = in_valid & in_ready & ~in_bubble & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    assign w_in_pkt.instr   = in_instr;
    assign w_in_pkt.imm     = in_imm;
    assign w_in_pkt.pc      = in_pc;
    assign w_in_pkt.next_pc = in_next_pc;

    // Count state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CNT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Count next-state; flush overrides every other event.
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = CNT_EMPTY;
        end else begin
            case (r_state)
                CNT_EMPTY: begin
                    if (w_push) begin
                        w_state_next = CNT_ONE;
                    end else begin
                        w_state_next = CNT_EMPTY;
                    end
                end
                CNT_ONE: begin
                    if (w_push && !w_pop) begin
                        w_state_next = CNT_FULL;
                    end else if (w_pop && !w_push) begin
                        w_state_next = CNT_EMPTY;
                    end else begin
                        w_state_next = CNT_ONE;
                    end
                end
                CNT_FULL: begin
                    if (w_pop) begin
                        w_state_next = CNT_ONE;
                    end else begin
                        w_state_next = CNT_FULL;
                    end
                end
                default: begin
                    w_state_next = CNT_EMPTY;
                end
            endcase
        end
    end

    // Read/write pointers toggle between the two slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
        end else if (flush) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

    if_id_slot u_slot0 (
        .clk  (clk),
        .rst  (rst),
        .i_we (w_push & (r_wptr == 1'b0)),
        .i_d  (w_in_pkt),
        .o_q  (w_slot0)
    );

    if_id_slot u_slot1 (
        .clk  (clk),
        .rst  (rst),
        .i_we (w_push & (r_wptr == 1'b1)),
        .i_d  (w_in_pkt),
        .o_q  (w_slot1)
    );

    // Head fields are masked while empty; stale slot contents never leak out.
    always_comb begin
        w_head = (r_rptr == 1'b1) ? w_slot1 : w_slot0;
        if (out_valid) begin
            out_instr   = w_head.instr;
            out_imm     = w_head.imm;
            out_pc      = w_head.pc;
            out_next_pc = w_head.next_pc;
        end else begin
            out_instr   = NOP_INSTR;
            out_imm     = 16'h0000;
            out_pc      = 32'h0000_0000;
            out_next_pc = 32'h0000_0000;
        end
    end

    assign occupancy = r_state;

`ifdef IF_ID_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;

    // Dropped bubbles are counted even in a flush cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= 16'h0000;
        end else if (in_valid & in_bubble & in_ready) begin
            r_bubble_cnt <= sat_inc16(r_bubble_cnt);
        end
    end

    assign bubble_count = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed plan steps plus random
// traffic against a queue-based reference model.
module tb_if_id_buffer;
    import if_id_buffer_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [INSTR_W-1:0] in_imm;
    logic [PC_W-1:0]    in_pc;
    logic [PC_W-1:0]    in_next_pc;
    logic               in_bubble;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [INSTR_W-1:0] out_imm;
    logic [PC_W-1:0]    out_pc;
    logic [PC_W-1:0]    out_next_pc;
    logic [1:0]         occupancy;
`ifdef IF_ID_BUBBLE_CNT_EN
    logic [15:0]        bubble_count;
`endif

    fetch_pkt_t model_q[$];
    int         model_bub;
    int         n_vec;
    int         n_err;

    always #5 clk = ~clk;

    if_id_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_imm      (in_imm),
        .in_pc       (in_pc),
        .in_next_pc  (in_next_pc),
        .in_bubble   (in_bubble),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_next_pc (out_next_pc),
        .occupancy   (occupancy)
`ifdef IF_ID_BUBBLE_CNT_EN
        ,
        .bubble_count(bubble_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic fetch_pkt_t mkpkt(input logic [15:0] instr, input logic [31:0] pc);
        fetch_pkt_t p;
        p.instr   = instr;
        p.imm     = ~instr;
        p.pc      = pc;
        p.next_pc = pc + 32'd2;
        return p;
    endfunction

    // Compare every output against what the model queue says the head is.
    task automatic check_all(input string tag);
        fetch_pkt_t e;
        int         sz;
        sz = model_q.size();
        if (sz > 0) begin
            e = model_q[0];
        end else begin
            e = '0;
        end
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, sz > 0});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, sz < 2});
        chk({tag, ".occupancy"}, {30'd0, occupancy}, sz);
        chk({tag, ".instr"},     {16'd0, out_instr}, {16'd0, e.instr});
        chk({tag, ".imm"},       {16'd0, out_imm},   {16'd0, e.imm});
        chk({tag, ".pc"},        out_pc,             e.pc);
        chk({tag, ".next_pc"},   out_next_pc,        e.next_pc);
`ifdef IF_ID_BUBBLE_CNT_EN
        chk({tag, ".bubble_count"}, {16'd0, bubble_count}, model_bub);
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic step(input string tag, input logic v, input logic b, input logic f,
                        input logic r, input fetch_pkt_t p);
        bit can_take;
        bit do_push;
        bit do_pop;
        bit do_drop;
        in_valid   = v;
        in_bubble  = b;
        flush      = f;
        out_ready  = r;
        in_instr   = p.instr;
        in_imm     = p.imm;
        in_pc      = p.pc;
        in_next_pc = p.next_pc;
        can_take = (model_q.size() < 2);
        do_push  = v && can_take && !b && !f;
        do_pop   = (model_q.size() > 0) && r && !f;
        do_drop  = v && b && can_take;
        @(posedge clk);
        if (f) begin
            model_q.delete();
        end else begin
            if (do_pop) begin
                void'(model_q.pop_front());
            end
            if (do_push) begin
                model_q.push_back(p);
            end
        end
        if (do_drop && model_bub < 65535) begin
            model_bub++;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        fetch_pkt_t idle;
        idle      = mkpkt(16'h0000, 32'h0);
        n_vec     = 0;
        n_err     = 0;
        model_bub = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_bubble = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_instr  = 16'h0000;
        in_imm    = 16'h0000;
        in_pc     = 32'h0;
        in_next_pc = 32'h0;
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single packet through, then empty again.
        step("t1_push", 1'b1, 1'b0, 1'b0, 1'b1, mkpkt(16'h1234, 32'h20));
        chk("t1_instr_lit", {16'd0, out_instr}, 32'h0000_1234);
        chk("t1_pc_lit", out_pc, 32'h0000_0020);
        step("t1_pop", 1'b0, 1'b0, 1'b0, 1'b1, idle);
        chk("t1_nop_lit", {16'd0, out_instr}, 32'h0000_0000);

        // Three pushes under back-pressure; third is refused.
        step("t2_a", 1'b1, 1'b0, 1'b0, 1'b0, mkpkt(16'hA001, 32'h100));
        step("t2_b", 1'b1, 1'b0, 1'b0, 1'b0, mkpkt(16'hA002, 32'h102));
        chk("t2_full_ready_lit", {31'd0, in_ready}, 32'd0);
        step("t2_c", 1'b1, 1'b0, 1'b0, 1'b0, mkpkt(16'hA003, 32'h104));
        step("t2_d1", 1'b0, 1'b0, 1'b0, 1'b1, idle);
        chk("t2_second_lit", {16'd0, out_instr}, 32'h0000_A002);
        step("t2_d2", 1'b0, 1'b0, 1'b0, 1'b1, idle);

        // Bubble is dropped without storage.
        step("t3_bubble", 1'b1, 1'b1, 1'b0, 1'b0, mkpkt(16'hBBBB, 32'h22));
        chk("t3_occ_lit", {30'd0, occupancy}, 32'd0);
`ifdef IF_ID_BUBBLE_CNT_EN
        chk("t3_bub_lit", {16'd0, bubble_count}, 32'd1);
`endif

        // Flush from FULL with simultaneous push and pop.
        step("t4_a", 1'b1, 1'b0, 1'b0, 1'b0, mkpkt(16'hC001, 32'h200));
        step("t4_b", 1'b1, 1'b0, 1'b0, 1'b0, mkpkt(16'hC002, 32'h202));
        step("t4_flush", 1'b1, 1'b0, 1'b1, 1'b1, mkpkt(16'hC003, 32'h204));
        chk("t4_valid_lit", {31'd0, out_valid}, 32'd0);

        // ONE state push+pop repeatedly, wrapping pointers.
        step("t5_seed", 1'b1, 1'b0, 1'b0, 1'b0, mkpkt(16'hD000, 32'h300));
        for (int i = 1; i < 5; i++) begin
            step("t5_pp", 1'b1, 1'b0, 1'b0, 1'b1, mkpkt(16'hD000 + 16'(i), 32'h300 + 32'(2 * i)));
        end
        chk("t5_occ_lit", {30'd0, occupancy}, 32'd1);
        chk("t5_head_lit", {16'd0, out_instr}, 32'h0000_D004);

        // Asynchronous reset while FULL, observed before the next edge.
        step("t6_fill", 1'b1, 1'b0, 1'b0, 1'b0, mkpkt(16'hE001, 32'h400));
        #2;
        rst = 1'b0;
        #1;
        model_q.delete();
        model_bub = 0;
        check_all("t6_async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("t6_after", 1'b1, 1'b0, 1'b0, 1'b0, mkpkt(16'hE100, 32'h500));

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 2,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6,
                 mkpkt(16'($urandom), $urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
